cl_ocl_axil_regfile: RTL

CL_OCL_AXIL_REGFILE -- requirements
Module: cl_ocl_axil_regfile

---
 rtl/cl_ocl_axil_if.sv | 35 +++
 rtl/cl_ocl_axil_regfile.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cl_ocl_axil_if.sv
// AXI-Lite bundle for the OCL register window: five channels, 32-bit address and data.
// The master drives valids, addresses, write data and ready on responses; the slave the rest.
interface cl_ocl_axil_if;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready;

  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wready;

  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;

  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;

  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/cl_ocl_axil_regfile.sv
// Four-register AXI-Lite slave: HELLO scratch, virtual LEDs, virtual DIPs, free-running cycle
// counter. Independent single-outstanding read and write engines.
module cl_ocl_axil_regfile #(
  parameter logic [31:0] UNIMPL_VALUE = 32'hDEAD_BEEF,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0500
) (
  input  logic                clk_main_a0,
  input  logic                rst_main_n_sync,
  cl_ocl_axil_if.slave        axil,
  input  logic [15:0]         sh_cl_status_vdip,
  output logic [15:0]         cl_sh_status_vled
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam logic [1:0] SelHello = 2'd0;
  localparam logic [1:0] SelVled  = 2'd1;
  localparam logic [1:0] SelVdip  = 2'd2;
  localparam logic [1:0] SelCycle = 2'd3;

  localparam logic [29:0] BaseWord = BASE_ADDR[31:2];

  // {mapped, register index}; the word offset wraps, so only offsets 0..3 land in the window.
  function automatic logic [2:0] decode(input logic [31:0] addr);
    logic [29:0] off;
    off = addr[31:2] - BaseWord;
    return {(off < 30'd4), off[1:0]};
  endfunction

  // Write engine state
  logic [1:0]  wstate_q, wstate_d;
  logic [2:0]  wsel_q, wsel_d;
  logic [1:0]  bresp_q, bresp_d;

  // Register contents
  logic [31:0] hello_q, hello_d;
  logic [15:0] vled_q, vled_d;
  logic [15:0] vdip_q, vdip_d;
  logic [31:0] cycle_q, cycle_d;

  // Read engine state
  logic        rstate_q, rstate_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  // Read mux
  logic [2:0]  rd_sel;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

  // ---------------------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------------------
  always_comb begin
    wstate_d = wstate_q;
    wsel_d   = wsel_q;
    bresp_d  = bresp_q;
    hello_d  = hello_q;
    vled_d   = vled_q;
    cycle_d  = cycle_q + 32'd1;

    unique case (wstate_q)
      W_IDLE: begin
        if (axil.awvalid) begin
          wsel_d   = decode(axil.awaddr);
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axil.wvalid) begin
          wstate_d = W_RESP;
          bresp_d  = RespOkay;
          if (!wsel_q[2]) begin
            bresp_d = RespSlverr;
          end else begin
            unique case (wsel_q[1:0])
              SelHello: begin
                for (int i = 0; i < 4; i++) begin
                  if (axil.wstrb[i]) hello_d[8*i +: 8] = axil.wdata[8*i +: 8];
                end
              end
              SelVled: begin
                // Upper half of VLED does not exist; bytes 2-3 are dropped.
                for (int i = 0; i < 2; i++) begin
                  if (axil.wstrb[i]) vled_d[8*i +: 8] = axil.wdata[8*i +: 8];
                end
              end
              SelVdip: bresp_d = RespSlverr;
              SelCycle: cycle_d = '0;
              default: ;
            endcase
          end
        end
      end
      W_RESP: begin
        if (axil.bready) begin
          wstate_d = W_IDLE;
          bresp_d  = RespOkay;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  assign vdip_d = sh_cl_status_vdip;

  // ---------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------
  always_comb begin
    rd_sel  = decode(axil.araddr);
    rd_word = UNIMPL_VALUE;
    rd_resp = RespSlverr;
    if (rd_sel[2]) begin
      rd_resp = RespOkay;
      unique case (rd_sel[1:0])
        SelHello: rd_word = {hello_q[7:0], hello_q[15:8], hello_q[23:16], hello_q[31:24]};
        SelVled:  rd_word = {16'h0000, vled_q};
        SelVdip:  rd_word = {16'h0000, vdip_q};
        SelCycle: rd_word = cycle_q;
        default:  rd_word = UNIMPL_VALUE;
      endcase
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    unique case (rstate_q)
      R_IDLE: begin
        if (axil.arvalid) begin
          rstate_d = R_DATA;
          rdata_d  = rd_word;
          rresp_d  = rd_resp;
        end
      end
      R_DATA: begin
        if (axil.rready) begin
          rstate_d = R_IDLE;
          rdata_d  = '0;
          rresp_d  = RespOkay;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      wstate_q <= W_IDLE;
      wsel_q   <= '0;
      bresp_q  <= RespOkay;
      hello_q  <= '0;
      vled_q   <= '0;
      vdip_q   <= '0;
      cycle_q  <= '0;
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else begin
      wstate_q <= wstate_d;
      wsel_q   <= wsel_d;
      bresp_q  <= bresp_d;
      hello_q  <= hello_d;
      vled_q   <= vled_d;
      vdip_q   <= vdip_d;
      cycle_q  <= cycle_d;
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // Address readies drop combinationally with reset so nothing is accepted while it is held.
  assign axil.awready = rst_main_n_sync && (wstate_q == W_IDLE);
  assign axil.wready  = (wstate_q == W_DATA);
  assign axil.bvalid  = (wstate_q == W_RESP);
  assign axil.bresp   = bresp_q;

  assign axil.arready = rst_main_n_sync && (rstate_q == R_IDLE);
  assign axil.rvalid  = (rstate_q == R_DATA);
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = rresp_q;

  assign cl_sh_status_vled = vled_q;

endmodule
